// File: rtl/beat_window_buffer.sv
// Header window for the packet parser: captures the first DEPTH beats of each
// AXI-Stream packet. Optional macro BEAT_WINDOW_ZERO_FILL_EN clears unused slots.
package pp_package;
  localparam int TDATA_WIDTH = 32;
endpackage

module beat_window_buffer #(
  parameter int DATA_W = pp_package::TDATA_WIDTH,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       s_tdata,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic [DATA_W*DEPTH-1:0] hdr_data,
  output logic [CNT_W-1:0]        hdr_beats,
  output logic                    hdr_short,
  output logic                    hdr_valid,
  input  logic                    hdr_ready
);

  typedef enum logic [1:0] {FILL, HOLD, SKIP} state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               pkt_done;
  logic               accept;
  logic [DATA_W-1:0]  slot [DEPTH];

  // The window is closed to new beats only while it is being offered downstream.
  assign s_tready = !rst && (state != HOLD);
  assign accept   = s_tvalid && s_tready;
  assign cnt_inc  = cnt + 1'b1;

  for (genvar g = 0; g < DEPTH; g++) begin : g_pack
    assign hdr_data[g*DATA_W +: DATA_W] = slot[g];
  end

  // NOTE: every register here uses <= so all next-state terms see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      cnt       <= '0;
      pkt_done  <= 1'b0;
      hdr_valid <= 1'b0;
      hdr_short <= 1'b0;
      hdr_beats <= '0;
      // NOTE: the slot array is reset on purpose: hdr_data has a defined reset value.
      for (int k = 0; k < DEPTH; k++) slot[k] <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            for (int k = 0; k < DEPTH; k++) begin
              if (CNT_W'(k) == cnt) slot[k] <= s_tdata;
`ifdef BEAT_WINDOW_ZERO_FILL_EN
              else if (s_tlast && CNT_W'(k) > cnt) slot[k] <= '0;
`endif
            end
            cnt <= cnt_inc;
            if (s_tlast || cnt_inc == DEPTH_C) begin
              state     <= HOLD;
              hdr_valid <= 1'b1;
              pkt_done  <= s_tlast;
              hdr_beats <= cnt_inc;
              hdr_short <= s_tlast && (cnt_inc < DEPTH_C);
            end
          end
        end
        HOLD: begin
          if (hdr_ready) begin
            hdr_valid <= 1'b0;
            cnt       <= '0;
            // A packet that already ended needs no tail discard.
            state     <= pkt_done ? FILL : SKIP;
          end
        end
        SKIP: begin
          if (accept && s_tlast) state <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_beat_window_buffer.sv
// Self-checking bench for beat_window_buffer (DEPTH=4) with a packet-level
// reference model; define BEAT_WINDOW_ZERO_FILL_EN to match a zero-fill build.
module tb_beat_window_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [DW-1:0]         s_tdata;
  logic                  s_tvalid;
  logic                  s_tlast;
  logic                  s_tready;
  logic [DW*DEPTH-1:0]   hdr_data;
  logic [CNT_W-1:0]      hdr_beats;
  logic                  hdr_short;
  logic                  hdr_valid;
  logic                  hdr_ready;

  beat_window_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .hdr_data(hdr_data), .hdr_beats(hdr_beats), .hdr_short(hdr_short),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] data; bit last; } beat_t;
  typedef struct { logic [DW*DEPTH-1:0] data; int beats; bit short_f; } win_t;

  beat_t          tx_q[$];
  win_t           exp_q[$];
  win_t           got_q[$];
  logic [DW-1:0]  shadow [DEPTH];
  int             m_idx;

  int checks = 0;
  int errors = 0;
  int lat_err, stable_err, ready_err, valid_cycles;
  bit timed_out;

  function automatic logic [DW*DEPTH-1:0] win4(input logic [DW-1:0] s0, s1, s2, s3);
    return {s3, s2, s1, s0};
  endfunction

  task automatic push_beats(input int first, input int len, input bit last_at_end);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = DW'(first + i);
      b.last = last_at_end && (i == len - 1);
      tx_q.push_back(b);
    end
  endtask

  task automatic push_rand_pkt(input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = $urandom;
      b.last = (i == len - 1);
      tx_q.push_back(b);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) shadow[k] = '0;
    m_idx = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  // Packet-level model: the first DEPTH beats of each packet form one window.
  task automatic model_accept(input beat_t b, output bit pushed);
    win_t w;
    pushed = 0;
    if (m_idx < DEPTH) begin
      shadow[m_idx] = b.data;
      if (b.last || m_idx == DEPTH - 1) begin
        w.beats   = m_idx + 1;
        w.short_f = (m_idx + 1 < DEPTH);
`ifdef BEAT_WINDOW_ZERO_FILL_EN
        for (int k = m_idx + 1; k < DEPTH; k++) shadow[k] = '0;
`endif
        for (int k = 0; k < DEPTH; k++) w.data[k*DW +: DW] = shadow[k];
        exp_q.push_back(w);
        pushed = 1;
      end
    end
    m_idx = b.last ? 0 : m_idx + 1;
  endtask

  // Samples handshakes just before the edge, then returns at edge + 1.
  task automatic tick(output bit acc, output bit hs);
    win_t w;
    #1;
    acc = s_tvalid && s_tready;
    hs  = hdr_valid && hdr_ready;
    if (hs) begin
      w.data = hdr_data; w.beats = int'(hdr_beats); w.short_f = hdr_short;
      got_q.push_back(w);
    end
    @(posedge clk);
    #1;
  endtask

  // vmode: 0 always valid, 1 toggling, 2 random-but-held. rmode: 0 ready, 1 random, 2 stall 5.
  task automatic run(input int vmode, input int rmode, input int max_cycles);
    bit acc, hs, pushed, prev_v, tog;
    int hold, cyc;
    logic [DW*DEPTH-1:0] prev_d;
    logic [CNT_W-1:0]    prev_b;
    logic                prev_s;
    beat_t               b;
    lat_err = 0; stable_err = 0; ready_err = 0; valid_cycles = 0; timed_out = 0;
    hold = 0; cyc = 0; tog = 0;
    prev_v = hdr_valid; prev_d = hdr_data; prev_b = hdr_beats; prev_s = hdr_short;
    s_tvalid = 0;
    while (!(tx_q.size() == 0 && got_q.size() == exp_q.size() && hdr_valid === 1'b0)) begin
      if (cyc >= max_cycles) begin timed_out = 1; break; end
      cyc++;
      if (tx_q.size() == 0) s_tvalid = 0;
      else case (vmode)
        0: s_tvalid = 1;
        1: begin tog = !tog; s_tvalid = tog; end
        default: if (!s_tvalid) s_tvalid = ($urandom_range(0, 2) != 0);
      endcase
      if (tx_q.size() != 0) begin s_tdata = tx_q[0].data; s_tlast = tx_q[0].last; end
      case (rmode)
        0: hdr_ready = 1;
        1: hdr_ready = 1'($urandom_range(0, 1));
        default: hdr_ready = (hold > 5);
      endcase
      tick(acc, hs);
      pushed = 0;
      if (hs) hold = 0;
      if (acc) begin
        b = tx_q.pop_front();
        model_accept(b, pushed);
        if (vmode == 2) s_tvalid = 0;
      end
      if ((hdr_valid === 1'b1 && prev_v !== 1'b1) != pushed) lat_err++;
      if (hdr_valid === 1'b1 && prev_v === 1'b1 && !hs &&
          (hdr_data !== prev_d || hdr_beats !== prev_b || hdr_short !== prev_s)) stable_err++;
      if (s_tready !== !hdr_valid) ready_err++;
      if (hdr_valid === 1'b1) begin valid_cycles++; hold++; end
      prev_v = hdr_valid; prev_d = hdr_data; prev_b = hdr_beats; prev_s = hdr_short;
    end
    s_tvalid = 0;
    hdr_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1; s_tvalid = 1; s_tdata = '0; s_tlast = 0; hdr_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b want 0", s_tready); end
    checks++; if (hdr_valid !== 1'b0 || hdr_short !== 1'b0 || hdr_beats !== '0) begin
      errors++; $display("FAIL reset_flags: valid %b short %b beats %0d want 0 0 0", hdr_valid, hdr_short, hdr_beats); end
    checks++; if (hdr_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", hdr_data); end
    rst = 0; s_tvalid = 0;
    #1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_release_tready: got %b want 1", s_tready); end
    model_reset();
  endtask

  task automatic test_full_packet();
    got_q.delete(); exp_q.delete();
    push_beats(1, 4, 1);
    run(0, 0, 100);
    checks++; if (lat_err || stable_err || ready_err || timed_out) begin errors++;
      $display("FAIL full_proto: lat %0d stable %0d ready %0d timeout %0d want 0", lat_err, stable_err, ready_err, timed_out); end
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL full_count: got %0d want 1", got_q.size()); end
    else if (got_q[0].data !== win4(1, 2, 3, 4) || got_q[0].beats != 4 || got_q[0].short_f != 0) begin errors++;
      $display("FAIL full_window: got %h/%0d/%0d want %h/4/0", got_q[0].data, got_q[0].beats, got_q[0].short_f, win4(1, 2, 3, 4)); end
    checks++; if (s_tready !== 1'b1 || hdr_valid !== 1'b0) begin errors++;
      $display("FAIL full_after: tready %b valid %b want 1 0", s_tready, hdr_valid); end
  endtask

  task automatic test_long_packet();
    got_q.delete(); exp_q.delete();
    push_beats(1, 8, 1);
    push_beats(9, 4, 1);
    run(0, 0, 200);
    checks++; if (lat_err || stable_err || ready_err || timed_out) begin errors++;
      $display("FAIL long_proto: lat %0d stable %0d ready %0d timeout %0d want 0", lat_err, stable_err, ready_err, timed_out); end
    checks++;
    if (got_q.size() != 2) begin errors++; $display("FAIL long_count: got %0d want 2", got_q.size()); end
    else begin
      if (got_q[0].data !== win4(1, 2, 3, 4) || got_q[0].beats != 4 || got_q[0].short_f != 0) begin errors++;
        $display("FAIL long_window0: got %h/%0d/%0d want %h/4/0", got_q[0].data, got_q[0].beats, got_q[0].short_f, win4(1, 2, 3, 4)); end
      checks++;
      if (got_q[1].data !== win4(9, 10, 11, 12) || got_q[1].beats != 4 || got_q[1].short_f != 0) begin errors++;
        $display("FAIL long_window1: got %h/%0d/%0d want %h/4/0", got_q[1].data, got_q[1].beats, got_q[1].short_f, win4(9, 10, 11, 12)); end
    end
  endtask

  task automatic test_short_packet();
    logic [DW*DEPTH-1:0] want;
`ifdef BEAT_WINDOW_ZERO_FILL_EN
    want = win4(5, 6, 0, 0);
`else
    want = win4(5, 6, 11, 12);
`endif
    got_q.delete(); exp_q.delete();
    push_beats(5, 2, 1);
    run(0, 0, 100);
    checks++; if (lat_err || stable_err || ready_err || timed_out) begin errors++;
      $display("FAIL short_proto: lat %0d stable %0d ready %0d timeout %0d want 0", lat_err, stable_err, ready_err, timed_out); end
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL short_count: got %0d want 1", got_q.size()); end
    else if (got_q[0].data !== want || got_q[0].beats != 2 || got_q[0].short_f != 1) begin errors++;
      $display("FAIL short_window: got %h/%0d/%0d want %h/2/1", got_q[0].data, got_q[0].beats, got_q[0].short_f, want); end
  endtask

  task automatic test_stall();
    got_q.delete(); exp_q.delete();
    push_beats(30, 4, 0);
    push_beats(9, 1, 1);
    push_beats(40, 4, 1);
    run(0, 2, 200);
    checks++; if (lat_err || stable_err || ready_err || timed_out) begin errors++;
      $display("FAIL stall_proto: lat %0d stable %0d ready %0d timeout %0d want 0", lat_err, stable_err, ready_err, timed_out); end
    checks++; if (valid_cycles != 12) begin errors++; $display("FAIL stall_hold_cycles: got %0d want 12", valid_cycles); end
    checks++;
    if (got_q.size() != 2) begin errors++; $display("FAIL stall_count: got %0d want 2", got_q.size()); end
    else if (got_q[0].data !== win4(30, 31, 32, 33) || got_q[1].data !== win4(40, 41, 42, 43)) begin errors++;
      $display("FAIL stall_windows: got %h %h want %h %h", got_q[0].data, got_q[1].data, win4(30, 31, 32, 33), win4(40, 41, 42, 43)); end
  endtask

  task automatic test_reset_mid();
    got_q.delete(); exp_q.delete();
    push_beats(1, 2, 0);
    run(0, 0, 50);
    rst = 1; s_tvalid = 1; s_tdata = 99; s_tlast = 0;
    #1;
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL mid_reset_tready: got %b want 0", s_tready); end
    @(posedge clk);
    #1;
    checks++; if (hdr_valid !== 1'b0 || hdr_short !== 1'b0 || hdr_beats !== '0 || hdr_data !== '0) begin errors++;
      $display("FAIL mid_reset_outputs: valid %b short %b beats %0d data %h want all 0", hdr_valid, hdr_short, hdr_beats, hdr_data); end
    rst = 0; s_tvalid = 0;
    model_reset();
    push_beats(7, 4, 1);
    run(0, 0, 100);
    checks++; if (lat_err || stable_err || ready_err || timed_out) begin errors++;
      $display("FAIL mid_proto: lat %0d stable %0d ready %0d timeout %0d want 0", lat_err, stable_err, ready_err, timed_out); end
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL mid_count: got %0d want 1", got_q.size()); end
    else if (got_q[0].data !== win4(7, 8, 9, 10) || got_q[0].beats != 4 || got_q[0].short_f != 0) begin errors++;
      $display("FAIL mid_window: got %h/%0d/%0d want %h/4/0", got_q[0].data, got_q[0].beats, got_q[0].short_f, win4(7, 8, 9, 10)); end
  endtask

  task automatic test_back_to_back();
    got_q.delete(); exp_q.delete();
    for (int p = 0; p < 6; p++) push_rand_pkt($urandom_range(1, 7));
    run(1, 0, 1000);
    checks++; if (lat_err || stable_err || ready_err || timed_out) begin errors++;
      $display("FAIL b2b_proto: lat %0d stable %0d ready %0d timeout %0d want 0", lat_err, stable_err, ready_err, timed_out); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i].data !== exp_q[i].data || got_q[i].beats != exp_q[i].beats || got_q[i].short_f != exp_q[i].short_f) begin errors++;
        $display("FAIL b2b_window%0d: got %h/%0d/%0d want %h/%0d/%0d", i, got_q[i].data, got_q[i].beats, got_q[i].short_f,
                 exp_q[i].data, exp_q[i].beats, exp_q[i].short_f); end
    end
  endtask

  task automatic test_random();
    got_q.delete(); exp_q.delete();
    for (int p = 0; p < 25; p++) push_rand_pkt($urandom_range(1, 9));
    run(2, 1, 4000);
    checks++; if (lat_err || stable_err || ready_err || timed_out) begin errors++;
      $display("FAIL rand_proto: lat %0d stable %0d ready %0d timeout %0d want 0", lat_err, stable_err, ready_err, timed_out); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i].data !== exp_q[i].data || got_q[i].beats != exp_q[i].beats || got_q[i].short_f != exp_q[i].short_f) begin errors++;
        $display("FAIL rand_window%0d: got %h/%0d/%0d want %h/%0d/%0d", i, got_q[i].data, got_q[i].beats, got_q[i].short_f,
                 exp_q[i].data, exp_q[i].beats, exp_q[i].short_f); end
    end
  endtask

  initial begin
    test_reset();
    test_full_packet();
    test_long_packet();
    test_short_packet();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
